// File: rtl/risc15_mem_arbiter.sv
// Two-port round-robin arbiter giving the core and a host loader shared access
// to the single unified memory, with bounded bursts under contention.
module risc15_mem_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              c_req,
  input  logic              h_req,
  input  logic              c_we,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              c_gnt,
  output logic              h_gnt,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] BURST_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    HOST = 2'd2
  } owner_t;

  owner_t            owner_r, owner_nxt_s;
  owner_t            last_r, last_nxt_s;
  logic [CNT_W-1:0]  burst_cnt_r, burst_nxt_s;
  logic [DATA_W-1:0] c_rdata_r, h_rdata_r;
  logic              xfer_c_s, xfer_h_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= BURST_MAX) begin
      sat_inc = BURST_MAX;
    end else begin
      sat_inc = cnt + BURST_ONE;
    end
  endfunction

  assign c_gnt      = (owner_r == CORE);
  assign h_gnt      = (owner_r == HOST);
  assign xfer_c_s   = c_req & c_gnt;
  assign xfer_h_s   = h_req & h_gnt;
  assign core_stall = c_req & ~c_gnt;
  assign c_rdata    = c_rdata_r;
  assign h_rdata    = h_rdata_r;

  // Memory pin mux: the core port drives address/data whenever the host does not own the memory.
  always_comb begin
    mem_addr  = c_addr;
    mem_wdata = c_wdata;
    if (owner_r == HOST) begin
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
    end else begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end
    mem_we = (xfer_c_s & c_we) | (xfer_h_s & h_we);
    mem_re = (xfer_c_s & ~c_we) | (xfer_h_s & ~h_we);
  end

  // Next owner, burst count and round-robin pointer.
  always_comb begin
    owner_nxt_s = owner_r;
    if (!c_req && !h_req) begin
      owner_nxt_s = IDLE;
    end else if (c_req && !h_req) begin
      owner_nxt_s = CORE;
    end else if (!c_req && h_req) begin
      owner_nxt_s = HOST;
    end else begin
      case (owner_r)
        CORE:    owner_nxt_s = (burst_cnt_r == BURST_MAX) ? HOST : CORE;
        HOST:    owner_nxt_s = (burst_cnt_r == BURST_MAX) ? CORE : HOST;
        IDLE:    owner_nxt_s = (last_r == CORE) ? HOST : CORE;
        default: owner_nxt_s = IDLE;
      endcase
    end

    burst_nxt_s = burst_cnt_r;
    if (owner_nxt_s == IDLE) begin
      burst_nxt_s = BURST_ZERO;
    end else if (owner_nxt_s == owner_r) begin
      burst_nxt_s = sat_inc(burst_cnt_r);
    end else begin
      burst_nxt_s = BURST_ONE;
    end

    last_nxt_s = last_r;
    if (owner_nxt_s != IDLE) begin
      last_nxt_s = owner_nxt_s;
    end else begin
      last_nxt_s = last_r;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      owner_r     <= IDLE;
      last_r      <= HOST;
      burst_cnt_r <= BURST_ZERO;
    end else begin
      owner_r     <= owner_nxt_s;
      last_r      <= last_nxt_s;
      burst_cnt_r <= burst_nxt_s;
    end
  end

  // Read data capture; a wasted grant cycle or a write leaves the port's data untouched.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      c_rdata_r <= {DATA_W{1'b0}};
      h_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (xfer_c_s && !c_we) begin
        c_rdata_r <= mem_rdata;
      end
      if (xfer_h_s && !h_we) begin
        h_rdata_r <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_risc15_mem_arbiter.sv
// Directed self-checking bench for risc15_mem_arbiter with a behavioural memory
// and a read-data scoreboard fed from a bench-side reference memory.
module tb_risc15_mem_arbiter;

  logic        clk;
  logic        proc_rst;
  logic        c_req, h_req, c_we, h_we;
  logic [4:0]  c_addr, h_addr;
  logic [15:0] c_wdata, h_wdata;
  logic        c_gnt, h_gnt, core_stall, mem_we, mem_re;
  logic [15:0] c_rdata, h_rdata, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;

  logic [15:0] mem [0:31];
  logic [15:0] ref_mem [0:31];

  typedef struct {
    bit          port;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  risc15_mem_arbiter #(.ADDR_W(5), .DATA_W(16), .MAX_BURST(8)) dut (
    .clk(clk), .proc_rst(proc_rst),
    .c_req(c_req), .h_req(h_req), .c_we(c_we), .h_we(h_we),
    .c_addr(c_addr), .h_addr(h_addr), .c_wdata(c_wdata), .h_wdata(h_wdata),
    .c_gnt(c_gnt), .h_gnt(h_gnt), .c_rdata(c_rdata), .h_rdata(h_rdata),
    .core_stall(core_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk_int("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      chk16(e.port ? "h_rdata_sb" : "c_rdata_sb", e.port ? h_rdata : c_rdata, e.data);
    end
  endtask

  // Single access from idle: request, wait for grant, drop req the cycle after the transfer.
  task automatic do_access(input bit port, input bit we, input logic [4:0] addr,
                           input logic [15:0] wdata, input int exp_wait);
    int   waited;
    bit   timed_out;
    exp_t e;
    waited    = 0;
    timed_out = 1'b0;
    if (port) begin
      h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
    if (!we) begin
      e.port = port;
      e.data = ref_mem[addr];
      sb.push_back(e);
    end
    forever begin
      @(negedge clk);
      if ((port ? h_gnt : c_gnt) === 1'b1) break;
      waited++;
      if (waited > 20) begin
        timed_out = 1'b1;
        break;
      end
      next_cycle();
    end
    chk1("grant_timeout", timed_out, 1'b0);
    chk_int("grant_wait", waited, exp_wait);
    chk1("other_gnt_low", port ? c_gnt : h_gnt, 1'b0);
    chk1("xfer_mem_we", mem_we, we);
    chk1("xfer_mem_re", mem_re, ~we);
    chk16("xfer_mem_addr", {11'd0, mem_addr}, {11'd0, addr});
    if (we) ref_mem[addr] = wdata;
    next_cycle();
    if (port) h_req = 1'b0; else c_req = 1'b0;
    @(negedge clk);
    chk1("wasted_gnt", port ? h_gnt : c_gnt, 1'b1);
    chk1("wasted_we", mem_we, 1'b0);
    chk1("wasted_re", mem_re, 1'b0);
    if (!we) sb_check();
    next_cycle();
    @(negedge clk);
    chk1("released_c", c_gnt, 1'b0);
    chk1("released_h", h_gnt, 1'b0);
    next_cycle();
  endtask

  initial begin
    bit exp_c, exp_h;
    proc_rst = 1'b1;
    c_req = 1'b0; h_req = 1'b0; c_we = 1'b0; h_we = 1'b0;
    c_addr = 5'd0; h_addr = 5'd0; c_wdata = 16'd0; h_wdata = 16'd0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'd0;

    // Reset values
    @(negedge clk);
    chk1("rst_c_gnt", c_gnt, 1'b0);
    chk1("rst_h_gnt", h_gnt, 1'b0);
    chk16("rst_c_rdata", c_rdata, 16'd0);
    chk16("rst_h_rdata", h_rdata, 16'd0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_mem_re", mem_re, 1'b0);
    chk1("rst_stall", core_stall, 1'b0);
    next_cycle();
    proc_rst = 1'b0;
    next_cycle();

    // Preload through the host port
    do_access(1'b1, 1'b1, 5'd5, 16'hBEEF, 1);
    do_access(1'b1, 1'b1, 5'd7, 16'h5555, 1);
    do_access(1'b1, 1'b1, 5'd3, 16'h0000, 1);

    // Core read alone, cycle by cycle
    c_req = 1'b1; c_we = 1'b0; c_addr = 5'd5;
    sb.push_back('{1'b0, ref_mem[5]});
    @(negedge clk);
    chk1("cr_first_stall", core_stall, 1'b1);
    chk1("cr_first_gnt", c_gnt, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("cr_gnt", c_gnt, 1'b1);
    chk1("cr_stall", core_stall, 1'b0);
    chk1("cr_mem_re", mem_re, 1'b1);
    chk1("cr_mem_we", mem_we, 1'b0);
    chk16("cr_addr", {11'd0, mem_addr}, 16'd5);
    next_cycle();
    c_req = 1'b0;
    @(negedge clk);
    chk1("cr_wasted_gnt", c_gnt, 1'b1);
    chk1("cr_wasted_re", mem_re, 1'b0);
    chk1("cr_wasted_we", mem_we, 1'b0);
    sb_check();
    next_cycle();
    @(negedge clk);
    chk1("cr_idle_gnt", c_gnt, 1'b0);
    chk16("cr_rdata_held", c_rdata, 16'hBEEF);
    next_cycle();

    // Host read, host write 0x1234 to addr 3, then core reads it back
    do_access(1'b1, 1'b0, 5'd5, 16'd0, 1);
    do_access(1'b1, 1'b1, 5'd3, 16'h1234, 1);
    do_access(1'b0, 1'b0, 5'd3, 16'd0, 1);
    chk16("hw_cr_c_rdata", c_rdata, 16'h1234);
    chk16("hw_cr_h_rdata_kept", h_rdata, 16'hBEEF);

    // Reset in the middle of a host write cycle
    h_req = 1'b1; h_we = 1'b1; h_addr = 5'd7; h_wdata = 16'hAAAA;
    @(negedge clk);
    chk1("rw_wait_gnt", h_gnt, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("rw_gnt", h_gnt, 1'b1);
    chk1("rw_we_before", mem_we, 1'b1);
    #2;
    proc_rst = 1'b1;
    #1;
    chk1("rw_we_dropped", mem_we, 1'b0);
    chk1("rw_re", mem_re, 1'b0);
    chk1("rw_h_gnt", h_gnt, 1'b0);
    chk1("rw_c_gnt", c_gnt, 1'b0);
    chk16("rw_c_rdata", c_rdata, 16'd0);
    chk16("rw_h_rdata", h_rdata, 16'd0);
    h_req = 1'b0; h_we = 1'b0;
    next_cycle();
    proc_rst = 1'b0;

    // First tie after reset goes to core; 8-cycle bursts alternate
    c_req = 1'b1; c_we = 1'b0; c_addr = 5'd5;
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd3;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      exp_c = (cyc >= 1 && cyc <= 8) || (cyc == 17);
      exp_h = (cyc >= 9 && cyc <= 16);
      chk1("tie_c_gnt", c_gnt, exp_c);
      chk1("tie_h_gnt", h_gnt, exp_h);
      chk1("tie_stall", core_stall, ~exp_c);
      next_cycle();
    end
    c_req = 1'b0; h_req = 1'b0;
    @(negedge clk);
    chk1("tie_wasted_c", c_gnt, 1'b1);
    chk1("tie_wasted_re", mem_re, 1'b0);
    chk16("tie_c_rdata", c_rdata, ref_mem[5]);
    chk16("tie_h_rdata", h_rdata, ref_mem[3]);
    next_cycle();
    @(negedge clk);
    chk1("tie_idle_c", c_gnt, 1'b0);
    chk1("tie_idle_h", h_gnt, 1'b0);
    next_cycle();

    // Suppressed write left addr 7 intact
    do_access(1'b1, 1'b0, 5'd7, 16'd0, 1);
    chk16("rw_mem_intact", h_rdata, 16'h5555);

    // Alternating single requests
    do_access(1'b0, 1'b0, 5'd5, 16'd0, 1);
    do_access(1'b1, 1'b0, 5'd3, 16'd0, 1);
    do_access(1'b0, 1'b1, 5'd9, 16'h0F0F, 1);
    do_access(1'b1, 1'b0, 5'd9, 16'd0, 1);
    chk_int("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
